// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: buffers dispatched ops, snoops the
// ALU/LSB result buses to wake pending operands, and issues the lowest ready entry.
module reservation_station #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        dispatch_rs_en,
  input  logic [5:0]  dis_opcode,
  input  logic [3:0]  dis_rob_id,
  input  logic [31:0] Vi,
  input  logic [31:0] Vj,
  input  logic [3:0]  Qi,
  input  logic [3:0]  Qj,
  input  logic        Oi,
  input  logic        Oj,
  input  logic [31:0] imm_from_dpc,
  input  logic [31:0] once_pc_from_dpc,
  input  logic        is_br_from_dpc,
  input  logic        is_ok,
  input  logic [31:0] val_from_alu,
  input  logic [3:0]  rob_id_from_alu,
  input  logic        lsb_ok,
  input  logic [31:0] val_from_lsb,
  input  logic [3:0]  rob_id_from_lsb,
  input  logic        is_clear,
  output logic        rs_full,
  output logic        alu_en,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_v1,
  output logic [31:0] alu_v2,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_pc,
  output logic [3:0]  alu_rob_id,
  output logic        alu_is_br
);

  typedef struct packed {
    logic        busy;
    logic [5:0]  opcode;
    logic [3:0]  rob_id;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic        o1;
    logic        o2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        is_br;
  } entry_t;

  entry_t entry_r [RS_SIZE];

  logic [RS_SIZE-1:0]  busy_vec_s;
  logic [RS_SIZE-1:0]  ready_vec_s;
  logic [RS_IDX_W-1:0] free_idx_s;
  logic [RS_IDX_W-1:0] issue_idx_s;
  logic                free_found_s;
  logic                issue_found_s;
  entry_t              ins_entry_s;
  logic [32:0]         ins_op1_s;
  logic [32:0]         ins_op2_s;

  // Resolve one operand against both result buses; returns {ready, value}, ALU wins ties.
  function automatic logic [32:0] snoop(
    input logic        o,
    input logic [3:0]  q,
    input logic [31:0] v,
    input logic        a_ok,
    input logic [3:0]  a_id,
    input logic [31:0] a_val,
    input logic        l_ok,
    input logic [3:0]  l_id,
    input logic [31:0] l_val
  );
    logic [32:0] res;
    if (o) begin
      res = {1'b1, v};
    end else if (a_ok && (a_id == q)) begin
      res = {1'b1, a_val};
    end else if (l_ok && (l_id == q)) begin
      res = {1'b1, l_val};
    end else begin
      res = {1'b0, v};
    end
    return res;
  endfunction

  // Busy/ready vectors and lowest-index free and ready slot selection.
  always_comb begin
    busy_vec_s    = '0;
    ready_vec_s   = '0;
    free_idx_s    = '0;
    issue_idx_s   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      busy_vec_s[i]  = entry_r[i].busy;
      ready_vec_s[i] = entry_r[i].busy & entry_r[i].o1 & entry_r[i].o2;
      free_idx_s     = entry_r[i].busy ? free_idx_s : RS_IDX_W'(i);
      issue_idx_s    = ready_vec_s[i] ? RS_IDX_W'(i) : issue_idx_s;
    end
    free_found_s  = ~(&busy_vec_s);
    issue_found_s = |ready_vec_s;
  end

  assign rs_full = &busy_vec_s;

  // Incoming entry with same-cycle forwarding from the result buses.
  always_comb begin
    ins_op1_s = snoop(Oi, Qi, Vi, is_ok, rob_id_from_alu, val_from_alu,
                      lsb_ok, rob_id_from_lsb, val_from_lsb);
    ins_op2_s = snoop(Oj, Qj, Vj, is_ok, rob_id_from_alu, val_from_alu,
                      lsb_ok, rob_id_from_lsb, val_from_lsb);
    ins_entry_s        = '0;
    ins_entry_s.busy   = 1'b1;
    ins_entry_s.opcode = dis_opcode;
    ins_entry_s.rob_id = dis_rob_id;
    ins_entry_s.o1     = ins_op1_s[32];
    ins_entry_s.v1     = ins_op1_s[31:0];
    ins_entry_s.q1     = Qi;
    ins_entry_s.o2     = ins_op2_s[32];
    ins_entry_s.v2     = ins_op2_s[31:0];
    ins_entry_s.q2     = Qj;
    ins_entry_s.imm    = imm_from_dpc;
    ins_entry_s.pc     = once_pc_from_dpc;
    ins_entry_s.is_br  = is_br_from_dpc;
  end

  // Entry state update (wakeup, issue, insert) and registered issue port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entry_r[i] <= '0;
      end
      alu_en     <= 1'b0;
      alu_opcode <= 6'd0;
      alu_v1     <= 32'd0;
      alu_v2     <= 32'd0;
      alu_imm    <= 32'd0;
      alu_pc     <= 32'd0;
      alu_rob_id <= 4'd0;
      alu_is_br  <= 1'b0;
    end else if (rdy) begin
      if (is_clear) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          entry_r[i].busy <= 1'b0;
        end
        alu_en <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (entry_r[i].busy) begin
            {entry_r[i].o1, entry_r[i].v1} <= snoop(entry_r[i].o1, entry_r[i].q1, entry_r[i].v1,
                is_ok, rob_id_from_alu, val_from_alu, lsb_ok, rob_id_from_lsb, val_from_lsb);
            {entry_r[i].o2, entry_r[i].v2} <= snoop(entry_r[i].o2, entry_r[i].q2, entry_r[i].v2,
                is_ok, rob_id_from_alu, val_from_alu, lsb_ok, rob_id_from_lsb, val_from_lsb);
          end
        end
        if (issue_found_s) begin
          alu_en                    <= 1'b1;
          alu_opcode                <= entry_r[issue_idx_s].opcode;
          alu_v1                    <= entry_r[issue_idx_s].v1;
          alu_v2                    <= entry_r[issue_idx_s].v2;
          alu_imm                   <= entry_r[issue_idx_s].imm;
          alu_pc                    <= entry_r[issue_idx_s].pc;
          alu_rob_id                <= entry_r[issue_idx_s].rob_id;
          alu_is_br                 <= entry_r[issue_idx_s].is_br;
          entry_r[issue_idx_s].busy <= 1'b0;
        end else begin
          alu_en <= 1'b0;
        end
        // Insert targets a slot free at cycle start, so it never collides with the issuing slot.
        if (dispatch_rs_en && free_found_s) begin
          entry_r[free_idx_s] <= ins_entry_s;
        end
      end
    end else begin
      alu_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station.
module tb_reservation_station;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        dispatch_rs_en;
  logic [5:0]  dis_opcode;
  logic [3:0]  dis_rob_id;
  logic [31:0] Vi, Vj;
  logic [3:0]  Qi, Qj;
  logic        Oi, Oj;
  logic [31:0] imm_from_dpc, once_pc_from_dpc;
  logic        is_br_from_dpc;
  logic        is_ok;
  logic [31:0] val_from_alu;
  logic [3:0]  rob_id_from_alu;
  logic        lsb_ok;
  logic [31:0] val_from_lsb;
  logic [3:0]  rob_id_from_lsb;
  logic        is_clear;
  logic        rs_full, alu_en, alu_is_br;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_id;

  int checks_cnt;
  int fail_cnt;

  reservation_station #(.RS_SIZE(8), .RS_IDX_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .dispatch_rs_en(dispatch_rs_en),
    .dis_opcode(dis_opcode), .dis_rob_id(dis_rob_id), .Vi(Vi), .Vj(Vj),
    .Qi(Qi), .Qj(Qj), .Oi(Oi), .Oj(Oj), .imm_from_dpc(imm_from_dpc),
    .once_pc_from_dpc(once_pc_from_dpc), .is_br_from_dpc(is_br_from_dpc),
    .is_ok(is_ok), .val_from_alu(val_from_alu), .rob_id_from_alu(rob_id_from_alu),
    .lsb_ok(lsb_ok), .val_from_lsb(val_from_lsb), .rob_id_from_lsb(rob_id_from_lsb),
    .is_clear(is_clear), .rs_full(rs_full), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_id(alu_rob_id), .alu_is_br(alu_is_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one instruction for one edge; imm/pc/is_br derive from the rob id.
  task automatic dispatch(input logic [5:0] op, input logic [3:0] rob,
                          input logic [31:0] vi_v, input logic [31:0] vj_v,
                          input logic [3:0] qi_v, input logic [3:0] qj_v,
                          input logic oi_v, input logic oj_v);
    dispatch_rs_en   = 1'b1;
    dis_opcode       = op;
    dis_rob_id       = rob;
    Vi = vi_v; Vj = vj_v; Qi = qi_v; Qj = qj_v; Oi = oi_v; Oj = oj_v;
    imm_from_dpc     = 32'h1000 + {28'd0, rob};
    once_pc_from_dpc = 32'h4000 + {28'd0, rob};
    is_br_from_dpc   = rob[0];
    step();
    dispatch_rs_en   = 1'b0;
  endtask

  initial begin
    checks_cnt = 0; fail_cnt = 0;
    rst = 1'b0; rdy = 1'b1; dispatch_rs_en = 1'b0; is_clear = 1'b0;
    dis_opcode = 6'd0; dis_rob_id = 4'd0; Vi = 32'd0; Vj = 32'd0;
    Qi = 4'd0; Qj = 4'd0; Oi = 1'b0; Oj = 1'b0;
    imm_from_dpc = 32'd0; once_pc_from_dpc = 32'd0; is_br_from_dpc = 1'b0;
    is_ok = 1'b0; val_from_alu = 32'd0; rob_id_from_alu = 4'd0;
    lsb_ok = 1'b0; val_from_lsb = 32'd0; rob_id_from_lsb = 4'd0;

    #12;
    check("rst_full", {31'd0, rs_full}, 32'd0);
    check("rst_en", {31'd0, alu_en}, 32'd0);
    check("rst_v1", alu_v1, 32'd0);
    check("rst_rob", {28'd0, alu_rob_id}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Both operands ready: issue one edge after insert
    dispatch(6'h01, 4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1);
    check("add_not_yet", {31'd0, alu_en}, 32'd0);
    step();
    check("add_en", {31'd0, alu_en}, 32'd1);
    check("add_v1", alu_v1, 32'd5);
    check("add_v2", alu_v2, 32'd7);
    check("add_rob", {28'd0, alu_rob_id}, 32'd3);
    check("add_op", {26'd0, alu_opcode}, 32'h01);
    check("add_imm", alu_imm, 32'h1003);
    check("add_pc", alu_pc, 32'h4003);
    check("add_br", {31'd0, alu_is_br}, 32'd1);
    step();
    check("add_en_off", {31'd0, alu_en}, 32'd0);
    check("add_full", {31'd0, rs_full}, 32'd0);

    // Pending operand woken by ALU broadcast
    dispatch(6'h02, 4'd5, 32'h1234, 32'h11, 4'd2, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_idle", {31'd0, alu_en}, 32'd0);
    end
    is_ok = 1'b1; rob_id_from_alu = 4'd2; val_from_alu = 32'hDEAD;
    step();
    is_ok = 1'b0;
    check("wake_edge", {31'd0, alu_en}, 32'd0);
    step();
    check("wake_en", {31'd0, alu_en}, 32'd1);
    check("wake_v1", alu_v1, 32'hDEAD);
    check("wake_v2", alu_v2, 32'h11);
    check("wake_rob", {28'd0, alu_rob_id}, 32'd5);
    step();

    // Insert-time forwarding from LSB
    lsb_ok = 1'b1; rob_id_from_lsb = 4'd4; val_from_lsb = 32'h10;
    dispatch(6'h03, 4'd6, 32'd1, 32'h0, 4'd0, 4'd4, 1'b1, 1'b0);
    lsb_ok = 1'b0;
    step();
    check("fwd_en", {31'd0, alu_en}, 32'd1);
    check("fwd_v2", alu_v2, 32'h10);
    check("fwd_rob", {28'd0, alu_rob_id}, 32'd6);
    step();

    // Both buses match at insert: ALU value wins
    is_ok = 1'b1; rob_id_from_alu = 4'd7; val_from_alu = 32'hA;
    lsb_ok = 1'b1; rob_id_from_lsb = 4'd7; val_from_lsb = 32'hB;
    dispatch(6'h04, 4'd7, 32'd0, 32'd2, 4'd7, 4'd0, 1'b0, 1'b1);
    is_ok = 1'b0; lsb_ok = 1'b0;
    step();
    check("prio_en", {31'd0, alu_en}, 32'd1);
    check("prio_v1", alu_v1, 32'hA);
    step();

    // Fill all 8 slots waiting on tag 9
    for (int i = 0; i < 8; i++) begin
      dispatch(6'(i), 4'(i), 32'd0, 32'(i), 4'd9, 4'd0, 1'b0, 1'b1);
    end
    check("full_set", {31'd0, rs_full}, 32'd1);
    dispatch(6'h3F, 4'd15, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    check("full_hold", {31'd0, rs_full}, 32'd1);
    check("full_noiss", {31'd0, alu_en}, 32'd0);
    is_ok = 1'b1; rob_id_from_alu = 4'd9; val_from_alu = 32'h99;
    step();
    is_ok = 1'b0;
    check("full_wake", {31'd0, alu_en}, 32'd0);
    // Dispatch on the first issue edge while still full must be rejected
    dispatch(6'h3E, 4'd14, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    check("order_en0", {31'd0, alu_en}, 32'd1);
    check("order_rob0", {28'd0, alu_rob_id}, 32'd0);
    check("order_full", {31'd0, rs_full}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      check("order_en", {31'd0, alu_en}, 32'd1);
      check("order_rob", {28'd0, alu_rob_id}, 32'(i));
      check("order_v1", alu_v1, 32'h99);
      check("order_v2", alu_v2, 32'(i));
    end
    step();
    check("order_done", {31'd0, alu_en}, 32'd0);

    // Flush discards entries, same-cycle dispatch and broadcasts
    for (int i = 0; i < 3; i++) begin
      dispatch(6'h05, 4'(8 + i), 32'd0, 32'd0, 4'd12, 4'd0, 1'b0, 1'b1);
    end
    is_clear = 1'b1; is_ok = 1'b1; rob_id_from_alu = 4'd12; val_from_alu = 32'h5;
    dispatch(6'h06, 4'd13, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
    is_clear = 1'b0; is_ok = 1'b0;
    check("clr_en", {31'd0, alu_en}, 32'd0);
    check("clr_full", {31'd0, rs_full}, 32'd0);
    step();
    check("clr_noins", {31'd0, alu_en}, 32'd0);
    is_ok = 1'b1;
    step();
    is_ok = 1'b0;
    step();
    check("clr_gone", {31'd0, alu_en}, 32'd0);

    // Async reset while issuing
    dispatch(6'h07, 4'd1, 32'h77, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    dispatch(6'h07, 4'd2, 32'h78, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    check("ar_en", {31'd0, alu_en}, 32'd1);
    check("ar_rob", {28'd0, alu_rob_id}, 32'd1);
    rst = 1'b0;
    #1;
    check("ar_en_off", {31'd0, alu_en}, 32'd0);
    check("ar_full", {31'd0, rs_full}, 32'd0);
    check("ar_v1", alu_v1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("ar_discard", {31'd0, alu_en}, 32'd0);

    // rdy=0 freezes issue
    dispatch(6'h08, 4'd2, 32'h22, 32'h33, 4'd0, 4'd0, 1'b1, 1'b1);
    rdy = 1'b0;
    step();
    check("rdy_hold1", {31'd0, alu_en}, 32'd0);
    step();
    check("rdy_hold2", {31'd0, alu_en}, 32'd0);
    rdy = 1'b1;
    step();
    check("rdy_en", {31'd0, alu_en}, 32'd1);
    check("rdy_v1", alu_v1, 32'h22);
    check("rdy_rob", {28'd0, alu_rob_id}, 32'd2);
    step();
    check("rdy_done", {31'd0, alu_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Buffers ALU-class instructions (non-load/store) accepted from the dispatcher.
- Each entry snoops the ALU and LSB result broadcasts to resolve pending operands.
- Issues one ready entry per cycle to the ALU.
- Sits between the dispatcher (upstream) and the ALU (downstream); the ROB drives flush.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2)
- RS_IDX_W, 3, log2(RS_SIZE)

Ports:
- clk input 1: system clock, rising edge
- rst input 1: asynchronous, active-low reset
- rdy input 1: global ready; 0 freezes the block
- dispatch_rs_en input 1: dispatcher presents an instruction this cycle
- dis_opcode input 6: internal opcode
- dis_rob_id input 4: destination ROB tag
- Vi, Vj input 32: operand values, meaningful when Oi/Oj=1
- Qi, Qj input 4: producer ROB tags, meaningful when Oi/Oj=0
- Oi, Oj input 1: operand ready flags
- imm_from_dpc input 32: immediate
- once_pc_from_dpc input 32: instruction pc
- is_br_from_dpc input 1: branch flag
- is_ok input 1: ALU broadcast valid
- val_from_alu input 32: ALU result
- rob_id_from_alu input 4: ALU result tag
- lsb_ok input 1: LSB broadcast valid
- val_from_lsb input 32: load result
- rob_id_from_lsb input 4: load result tag
- is_clear input 1: ROB misprediction flush
- rs_full output 1: no free entry
- alu_en output 1: issue valid
- alu_opcode output 6
- alu_v1, alu_v2 output 32
- alu_imm, alu_pc output 32
- alu_rob_id output 4
- alu_is_br output 1

Behaviour:
- Per-entry state: busy, opcode, rob_id, V1/V2, Q1/Q2, O1/O2, imm, pc, is_br.
- Reset (rst=0, async): all busy=0; rs_full=0; alu_en=0; all alu_* outputs 0.
- rdy=0: all entry state holds; alu_en registers 0; other alu_* hold.
- rs_full is combinational from registered state: 1 iff all RS_SIZE entries are busy.
- Insert:
  - On an edge with rdy=1, dispatch_rs_en=1, is_clear=0 and at least one entry free at cycle start, write the lowest-index free entry; busy=1.
  - If the block is full, dispatch is ignored. Dispatcher must not assert dispatch_rs_en when rs_full=1.
- Insert-time forwarding: if an incoming operand has O=0 and its Q matches a valid broadcast in the same cycle, store the broadcast value with O=1. The ALU broadcast has priority if both buses match.
- Wakeup: for every busy entry and each operand with O=0, a valid broadcast with a matching tag writes V and sets O=1 at the edge. Both buses may wake different operands in the same cycle.
- Ready: busy && O1 && O2, evaluated on registered state. A wakeup is therefore visible for selection one cycle after the broadcast edge.
- Issue select: lowest-index ready entry.
- Issue outputs: at the edge, alu_en<=1 and alu_* are loaded from the selected entry; that entry's busy<=0. With no ready entry, alu_en<=0.
- Latency: an entry inserted with both operands ready at edge k issues at edge k+1, i.e. alu_en is high in the cycle after edge k+1.
- Simultaneous insert and issue: allowed. Insert uses a slot free at cycle start, never the slot being issued. A full RS that issues this cycle still rejects dispatch this cycle.
- is_clear=1 (synchronous, with rdy=1): at the edge, all busy<=0 and alu_en<=0. Same-cycle dispatch and broadcasts are discarded. rs_full=0 next cycle.
- Tags are 4-bit ROB ids; tag 0 is a valid ROB id. Matching always requires O=0.
- Async reset mid-operation discards all entries immediately; the first edge after release behaves as an empty RS.

Test Plan:
- Reset, then insert ADD (rob 3, Vi=5, Vj=7, Oi=Oj=1) -> alu_en=1 one edge later, alu_v1=5, alu_v2=7, alu_rob_id=3; next cycle alu_en=0, rs_full=0.
- Insert entry with Oi=0, Qi=2; three idle cycles -> no issue. Then is_ok=1, rob_id_from_alu=2, val=0xDEAD -> issued the cycle after the wakeup edge with alu_v1=0xDEAD.
- Insert with Qj=4 while lsb_ok=1, rob_id_from_lsb=4, val=0x10 in the same cycle -> stored ready, issued next edge with alu_v2=0x10.
- Insert 8 entries all waiting on tag 9 -> rs_full=1; 9th dispatch ignored. Broadcast tag 9 -> entries issue in index order 0..7 on consecutive cycles; rs_full drops after the first issue edge.
- 3 busy entries, is_clear=1 together with dispatch_rs_en=1 -> all busy cleared, no alu_en, new instruction not stored.
- Pulse rst low mid-stream while alu_en=1 -> alu_en=0 immediately (async), rs_full=0; rdy=0 for 2 cycles with a ready entry -> no issue until rdy returns.
